rv_lsu: RTL and testbench

//  Parametrised multi-cycle load/store unit for the RV core. It replaces the single-cycle combinational umem access in the CPU datapath.

---
 rtl/rv_lsu.sv | 275 +++++++++++++++++++++++++++
 tb/tb_rv_lsu.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_lsu.sv
// rv_lsu: multi-cycle load/store unit for the RV core.
//
// Takes one load/store op per request handshake and computes the effective
// address as base + sext(offset). It then runs one access on a valid/ready
// memory port with byte enables, and returns the extended load data or an
// error code on a registered response port. Only one op is in flight at a time.
//
// Handshake rule, used by every port pair below: a transfer happens on the
// posedge where valid and ready are both high. The valid side holds its
// payload stable until that edge. After that edge the sender lowers valid on
// the next cycle unless it has a new transfer to offer.
//
// Ports:
//   clk, nreset                     clock and asynchronous active-low reset
//   req_valid/req_ready             op request; ready is high only in IDLE
//   req_we, req_funct3              store flag, RV access width/signedness
//   req_base, req_offset            rs1 value and signed 12-bit immediate
//   req_wdata, req_rd               store data, destination register tag
//   mem_valid/mem_ready             memory request handshake
//   mem_we, mem_addr, mem_wdata,    word-aligned request with lane-shifted
//   mem_be                          store data and byte enables
//   mem_rvalid, mem_rdata           load return (full word)
//   rsp_valid/rsp_ready             response handshake
//   rsp_rd, rsp_data, rsp_err       tag, extended load data, error code
//                                   (00 ok, 01 misaligned, 10 illegal, 11 timeout)
//   dbg_state                       current FSM state (0 IDLE,1 REQ,2 WAIT,3 RESP)
module rv_lsu #(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [XLEN-1:0]     req_base,
  input  logic [11:0]         req_offset,
  input  logic [XLEN-1:0]     req_wdata,
  input  logic [4:0]          req_rd,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_be,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [4:0]          rsp_rd,
  output logic [XLEN-1:0]     rsp_data,
  output logic [1:0]          rsp_err,
  output logic [1:0]          dbg_state
);

  localparam int   LANES = XLEN / 8;
  localparam int   LSB   = $clog2(LANES);
  // The counter can step one past TIMEOUT_CYCLES-1 when a handshake wins on
  // the timeout cycle, so it must be able to hold TIMEOUT_CYCLES.
  localparam int   CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic IS64  = (XLEN == 64);

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_ILL   = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LSB-1:0]   lane_q, lane_d;
  logic [1:0]       size_q, size_d;   // log2 of access size in bytes
  logic             uns_q, uns_d;

  logic               req_ready_d, mem_valid_d, mem_we_d, rsp_valid_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [XLEN-1:0]    mem_wdata_d, rsp_data_d;
  logic [LANES-1:0]   mem_be_d;
  logic [4:0]         rsp_rd_d;
  logic [1:0]         rsp_err_d;

  // Decode of the incoming request (only used in IDLE).
  logic [1:0]        dec_size;
  logic              dec_uns, dec_legal, dec_misal;
  logic [XLEN-1:0]   ea_x;
  logic [ADDR_W-1:0] ea;
  logic [LSB-1:0]    dec_lane;
  logic [2:0]        align_mask;
  logic [7:0]        be_mask;

  always_comb begin
    dec_size  = 2'd0;
    dec_uns   = 1'b0;
    dec_legal = 1'b0;
    case (req_funct3)
      3'b000: begin dec_size = 2'd0; dec_legal = 1'b1; end
      3'b001: begin dec_size = 2'd1; dec_legal = 1'b1; end
      3'b010: begin dec_size = 2'd2; dec_legal = 1'b1; end
      3'b011: begin dec_size = 2'd3; dec_legal = IS64; end
      3'b100: begin dec_size = 2'd0; dec_uns = 1'b1; dec_legal = !req_we; end
      3'b101: begin dec_size = 2'd1; dec_uns = 1'b1; dec_legal = !req_we; end
      3'b110: begin dec_size = 2'd2; dec_uns = 1'b1; dec_legal = IS64 && !req_we; end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    ea_x     = req_base + XLEN'($signed(req_offset));
    ea       = ADDR_W'(ea_x);
    dec_lane = ea_x[LSB-1:0];
    case (dec_size)
      2'd0:    begin align_mask = 3'b000; be_mask = 8'h01; end
      2'd1:    begin align_mask = 3'b001; be_mask = 8'h03; end
      2'd2:    begin align_mask = 3'b011; be_mask = 8'h0f; end
      default: begin align_mask = 3'b111; be_mask = 8'hff; end
    endcase
    dec_misal = |(ea_x[2:0] & align_mask);
  end

  // Load return: shift the addressed lane down, then extend from the access width.
  logic [XLEN-1:0] ld_shift, ld_ext;

  always_comb begin
    ld_shift = mem_rdata >> {lane_q, 3'b000};
    ld_ext   = ld_shift;
    case (size_q)
      2'd0: if (uns_q) ld_ext = XLEN'(ld_shift[7:0]);
            else       ld_ext = XLEN'($signed(ld_shift[7:0]));
      2'd1: if (uns_q) ld_ext = XLEN'(ld_shift[15:0]);
            else       ld_ext = XLEN'($signed(ld_shift[15:0]));
      2'd2: if (uns_q) ld_ext = XLEN'(ld_shift[31:0]);
            else       ld_ext = XLEN'($signed(ld_shift[31:0]));
      default: ld_ext = ld_shift;
    endcase
  end

  logic timeout_hit;
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (int'(cnt_q) >= TIMEOUT_CYCLES - 1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    size_d      = size_q;
    uns_d       = uns_q;
    req_ready_d = req_ready;
    mem_valid_d = mem_valid;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_be_d    = mem_be;
    rsp_valid_d = rsp_valid;
    rsp_rd_d    = rsp_rd;
    rsp_data_d  = rsp_data;
    rsp_err_d   = rsp_err;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          req_ready_d = 1'b0;
          rsp_rd_d    = req_rd;
          rsp_data_d  = '0;
          lane_d      = dec_lane;
          size_d      = dec_size;
          uns_d       = dec_uns;
          mem_we_d    = req_we;
          mem_addr_d  = ea & ~ADDR_W'(LANES - 1);
          mem_be_d    = LANES'(be_mask) << dec_lane;
          mem_wdata_d = req_wdata << {dec_lane, 3'b000};
          if (!dec_legal) begin
            // Illegal width is reported ahead of misalignment.
            rsp_valid_d = 1'b1;
            rsp_err_d   = ERR_ILL;
            state_d     = S_RESP;
          end else if (dec_misal) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = ERR_ALIGN;
            state_d     = S_RESP;
          end else begin
            mem_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_ready) begin
          // The handshake takes priority over a timeout on the same cycle.
          mem_valid_d = 1'b0;
          if (mem_we) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = ERR_OK;
            state_d     = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end else if (timeout_hit) begin
          mem_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_TMO;
          state_d     = S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_rvalid) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = ld_ext;
          rsp_err_d   = ERR_OK;
          state_d     = S_RESP;
        end else if (timeout_hit) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_TMO;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      lane_q    <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      req_ready <= 1'b1;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      rsp_valid <= 1'b0;
      rsp_rd    <= '0;
      rsp_data  <= '0;
      rsp_err   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lane_q    <= lane_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      req_ready <= req_ready_d;
      mem_valid <= mem_valid_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_be    <= mem_be_d;
      rsp_valid <= rsp_valid_d;
      rsp_rd    <= rsp_rd_d;
      rsp_data  <= rsp_data_d;
      rsp_err   <= rsp_err_d;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_rv_lsu.sv
// Directed bench for rv_lsu (XLEN=32, ADDR_W=32, TIMEOUT_CYCLES=8).
// Inputs are driven and outputs sampled on the falling edge. "Cycle n" is the
// view n falling edges after the rising edge that accepted the request.
module tb_rv_lsu;

  logic        clk, nreset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_base, req_wdata;
  logic [11:0] req_offset;
  logic [4:0]  req_rd;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        rsp_valid, rsp_ready;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err, dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  rv_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .nreset(nreset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // Checking
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input logic [1:0] err, input logic [4:0] rd);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_sb observed=response expected=queued_entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, rsp_valid, 1'b1);
      chk({tag, "_data"},  rsp_data,  e);
      chk({tag, "_err"},   rsp_err,   err);
      chk({tag, "_rd"},    rsp_rd,    rd);
    end
  endtask

  // Drivers
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] base,
                       input logic [11:0] off, input logic [31:0] wd, input logic [4:0] rd);
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_base = base; req_offset = off; req_wdata = wd; req_rd = rd;
    step();
    // Scramble the request fields so that only the latched copy can matter.
    req_valid  = 1'b0;
    req_we     = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_base   = $urandom;
    req_offset = 12'($urandom);
    req_wdata  = $urandom;
    req_rd     = 5'($urandom_range(0, 31));
  endtask

  // Load with mem_ready=1 and rvalid one cycle after accept; checks latency.
  task automatic load_simple(input string tag, input logic [2:0] f3, input logic [31:0] base,
                             input logic [11:0] off, input logic [31:0] rdata, input logic [4:0] rd,
                             input logic [31:0] exp_addr, input logic [3:0] exp_be,
                             input logic [31:0] exp_data);
    exp_q.push_back(exp_data);
    issue(1'b0, f3, base, off, 32'h0, rd);
    chk({tag, "_c1_mem_valid"}, mem_valid, 1'b1);
    chk({tag, "_c1_addr"},      mem_addr,  exp_addr);
    chk({tag, "_c1_be"},        mem_be,    exp_be);
    chk({tag, "_c1_we"},        mem_we,    1'b0);
    chk({tag, "_c1_req_ready"}, req_ready, 1'b0);
    step();
    chk({tag, "_c2_mem_valid"}, mem_valid, 1'b0);
    chk({tag, "_c2_rsp_valid"}, rsp_valid, 1'b0);
    mem_rvalid = 1'b1; mem_rdata = rdata;
    step();
    mem_rvalid = 1'b0; mem_rdata = $urandom;
    check_rsp({tag, "_c3"}, 2'b00, rd);
    step();
    chk({tag, "_c4_rsp_valid"}, rsp_valid, 1'b0);
  endtask

  task automatic store_simple(input string tag, input logic [2:0] f3, input logic [31:0] base,
                              input logic [11:0] off, input logic [31:0] wd, input logic [4:0] rd,
                              input logic [31:0] exp_addr, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata);
    exp_q.push_back(32'h0);
    issue(1'b1, f3, base, off, wd, rd);
    chk({tag, "_mem_valid"}, mem_valid, 1'b1);
    chk({tag, "_we"},        mem_we,    1'b1);
    chk({tag, "_addr"},      mem_addr,  exp_addr);
    chk({tag, "_be"},        mem_be,    exp_be);
    chk({tag, "_wdata"},     mem_wdata, exp_wdata);
    step();
    check_rsp(tag, 2'b00, rd);
    chk({tag, "_mem_valid_drop"}, mem_valid, 1'b0);
    step();
    chk({tag, "_rsp_drop"}, rsp_valid, 1'b0);
  endtask

  task automatic err_case(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] base, input logic [11:0] off,
                          input logic [4:0] rd, input logic [1:0] err);
    exp_q.push_back(32'h0);
    issue(we, f3, base, off, 32'hFFFF_FFFF, rd);
    check_rsp(tag, err, rd);
    chk({tag, "_no_mem_c1"}, mem_valid, 1'b0);
    step();
    chk({tag, "_rsp_drop"},  rsp_valid, 1'b0);
    chk({tag, "_no_mem_c2"}, mem_valid, 1'b0);
  endtask

  // Directed sequence
  initial begin
    nreset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_base = '0; req_offset = '0; req_wdata = '0; req_rd = '0;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0; rsp_ready = 1'b1;
    step(2);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_mem_addr",  mem_addr,  32'h0);
    chk("rst_mem_be",    mem_be,    4'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data",  rsp_data,  32'h0);
    chk("rst_rsp_err",   rsp_err,   2'b00);
    chk("rst_state",     dbg_state, 2'd0);
    nreset = 1'b1;
    step();

    // Loads
    load_simple("lw",     3'b010, 32'h100, 12'd4,   32'hDEADBEEF, 5'd7,  32'h104, 4'hF, 32'hDEADBEEF);
    load_simple("lb",     3'b000, 32'h100, 12'd3,   32'h80FFFFFF, 5'd1,  32'h100, 4'h8, 32'hFFFFFF80);
    load_simple("lbu",    3'b100, 32'h100, 12'd3,   32'h80FFFFFF, 5'd2,  32'h100, 4'h8, 32'h00000080);
    load_simple("lh",     3'b001, 32'h100, 12'd2,   32'h80FFFFFF, 5'd3,  32'h100, 4'hC, 32'hFFFF80FF);
    load_simple("lhu",    3'b101, 32'h100, 12'd2,   32'h80FFFFFF, 5'd4,  32'h100, 4'hC, 32'h000080FF);
    load_simple("lb_pos", 3'b000, 32'h100, 12'd1,   32'h00007F00, 5'd0,  32'h100, 4'h2, 32'h0000007F);
    load_simple("lw_neg", 3'b010, 32'h200, 12'hFFC, 32'h12345678, 5'd5,  32'h1FC, 4'hF, 32'h12345678);

    // Stores
    store_simple("sh", 3'b001, 32'h200, 12'd2, 32'h1234ABCD, 5'd6, 32'h200, 4'hC, 32'hABCD0000);
    store_simple("sb", 3'b000, 32'h200, 12'd1, 32'h1234ABCD, 5'd8, 32'h200, 4'h2, 32'h34ABCD00);
    store_simple("sw", 3'b010, 32'h300, 12'd0, 32'hCAFEF00D, 5'd9, 32'h300, 4'hF, 32'hCAFEF00D);

    // Errors: misaligned, illegal, illegal over misaligned
    err_case("lw_mis",   1'b0, 3'b010, 32'h100, 12'd2, 5'd10, 2'b01);
    err_case("lh_mis",   1'b0, 3'b001, 32'h100, 12'd1, 5'd11, 2'b01);
    err_case("sw_mis",   1'b1, 3'b010, 32'h200, 12'd2, 5'd12, 2'b01);
    err_case("ld_f011",  1'b0, 3'b011, 32'h100, 12'd0, 5'd13, 2'b10);
    err_case("st_f100",  1'b1, 3'b100, 32'h100, 12'd0, 5'd14, 2'b10);
    err_case("f111_mis", 1'b0, 3'b111, 32'h100, 12'd1, 5'd15, 2'b10);

    // Timeout in REQ: mem_ready held low for 8 request cycles
    mem_ready = 1'b0;
    exp_q.push_back(32'h0);
    issue(1'b0, 3'b010, 32'h100, 12'd0, 32'h0, 5'd3);
    for (int c = 1; c <= 8; c++) begin
      chk("to_mem_valid", mem_valid, 1'b1);
      chk("to_no_rsp",    rsp_valid, 1'b0);
      if (c < 8) step();
    end
    step();
    check_rsp("timeout", 2'b11, 5'd3);
    chk("to_mem_valid_drop", mem_valid, 1'b0);
    step();
    chk("to_rsp_drop", rsp_valid, 1'b0);
    // Late read data after the timeout is ignored.
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    step();
    mem_rvalid = 1'b0;
    chk("late_rvalid_no_rsp", rsp_valid, 1'b0);
    chk("late_rvalid_idle",   dbg_state, 2'd0);
    mem_ready = 1'b1;
    load_simple("lw_after_to", 3'b010, 32'h400, 12'd8, 32'h11112222, 5'd20, 32'h408, 4'hF, 32'h11112222);

    // Handshake on the timeout cycle wins
    mem_ready = 1'b0;
    exp_q.push_back(32'h55AA55AA);
    issue(1'b0, 3'b010, 32'h104, 12'd0, 32'h0, 5'd21);
    step(7);
    mem_ready = 1'b1;
    step();
    chk("hs_win_state",     dbg_state, 2'd2);
    chk("hs_win_mem_valid", mem_valid, 1'b0);
    chk("hs_win_no_rsp",    rsp_valid, 1'b0);
    mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
    step();
    mem_rvalid = 1'b0;
    check_rsp("hs_win", 2'b00, 5'd21);
    step();

    // Timeout in WAIT: accepted but no read data ever returns
    exp_q.push_back(32'h0);
    issue(1'b0, 3'b000, 32'h100, 12'd0, 32'h0, 5'd22);
    step(7);
    chk("wto_state",  dbg_state, 2'd2);
    chk("wto_no_rsp", rsp_valid, 1'b0);
    step();
    check_rsp("wait_timeout", 2'b11, 5'd22);
    step();

    // Response backpressure
    rsp_ready = 1'b0;
    exp_q.push_back(32'hA5A50001);
    issue(1'b0, 3'b010, 32'h108, 12'd0, 32'h0, 5'd31);
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'hA5A50001;
    step();
    mem_rvalid = 1'b0;
    check_rsp("bp", 2'b00, 5'd31);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_valid", rsp_valid, 1'b1);
      chk("bp_hold_data",  rsp_data,  32'hA5A50001);
      chk("bp_hold_err",   rsp_err,   2'b00);
      chk("bp_hold_rd",    rsp_rd,    5'd31);
      chk("bp_req_ready",  req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_release_valid", rsp_valid, 1'b0);
    chk("bp_release_ready", req_ready, 1'b1);

    // Reset asserted in WAIT
    issue(1'b0, 3'b010, 32'h10C, 12'd0, 32'h0, 5'd4);
    step();
    chk("mid_rst_in_wait", dbg_state, 2'd2);
    nreset = 1'b0;
    #1;
    chk("mid_rst_req_ready", req_ready, 1'b1);
    chk("mid_rst_mem_valid", mem_valid, 1'b0);
    chk("mid_rst_mem_addr",  mem_addr,  32'h0);
    chk("mid_rst_mem_be",    mem_be,    4'h0);
    chk("mid_rst_mem_we",    mem_we,    1'b0);
    chk("mid_rst_mem_wdata", mem_wdata, 32'h0);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst_rsp_data",  rsp_data,  32'h0);
    chk("mid_rst_rsp_err",   rsp_err,   2'b00);
    chk("mid_rst_rsp_rd",    rsp_rd,    5'd0);
    chk("mid_rst_state",     dbg_state, 2'd0);
    step();
    nreset = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
    step();
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_no_rsp", rsp_valid, 1'b0);
      step();
    end
    chk("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
